// File: rtl/bios_imem_loader.sv
// Boot sequencer for the i281 instruction memory: copies the BIOS image with the CPU
// halted, then shares the instruction-memory write port between BIOS reloads and user writes.
module bios_imem_loader #(
    parameter int WORDS = 32,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          Clock,
    input  logic          Reset_n,
    output logic [AW-1:0] bios_addr,
    input  logic [DW-1:0] bios_data,
    input  logic          bios_reload,
    input  logic          prog_req,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic          prog_ack,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_data,
    output logic          cpu_halt,
    output logic          load_done
);

    typedef enum logic {LOAD, RUN} state_t;

    localparam logic [AW:0] LAST_WORD = (AW+1)'(WORDS - 1);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

    state_t        state_reg;
    logic [AW:0]   cnt_reg;

    // The BIOS bank mux is driven straight from the counter so its word is ready this cycle.
    assign bios_addr = cnt_reg[AW-1:0];

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_reg <= LOAD;
            cnt_reg   <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            prog_ack  <= 1'b0;
            cpu_halt  <= 1'b1;
            load_done <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    imem_we   <= 1'b1;
                    imem_addr <= cnt_reg[AW-1:0];
                    imem_data <= bios_data;
                    prog_ack  <= 1'b0;
                    cpu_halt  <= 1'b1;
                    load_done <= 1'b0;
                    if (cnt_reg == LAST_WORD) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                RUN: begin
                    if (bios_reload) begin
                        // Reload pre-empts any pending user write; that request stays unacked.
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        imem_we   <= 1'b0;
                        prog_ack  <= 1'b0;
                        cpu_halt  <= 1'b1;
                        load_done <= 1'b0;
                    end else if (prog_req && !prog_ack) begin
                        imem_we   <= 1'b1;
                        imem_addr <= prog_addr;
                        imem_data <= prog_data;
                        prog_ack  <= 1'b1;
                        cpu_halt  <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        // Gap cycle after an ack keeps a held request to one write per ack.
                        imem_we   <= 1'b0;
                        prog_ack  <= 1'b0;
                        cpu_halt  <= prog_req;
                        load_done <= 1'b1;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bios_imem_loader.sv
// Randomized scenario bench for bios_imem_loader; expected writes and memory contents
// come from the BIOS table and a behavioural image of instruction memory.
module tb_bios_imem_loader;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [4:0]  bios_addr;
    logic [15:0] bios_data;
    logic        bios_reload = 1'b0;
    logic        prog_req = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        prog_ack;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [15:0] imem_data;
    logic        cpu_halt;
    logic        load_done;

    logic [15:0] bios_rom [32];
    logic [15:0] exp_mem  [32];
    logic [15:0] mem_cap  [32];
    logic [24:0] obs;
    logic [3:0]  ctl;
    int          checks = 0;
    int          passes = 0;

    bios_imem_loader #(.WORDS(32), .AW(5), .DW(16)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .bios_addr(bios_addr), .bios_data(bios_data), .bios_reload(bios_reload),
        .prog_req(prog_req), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_ack(prog_ack), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_data(imem_data), .cpu_halt(cpu_halt), .load_done(load_done)
    );

    always #5 Clock = ~Clock;

    assign bios_data = bios_rom[bios_addr];
    assign obs = {imem_we, imem_addr, imem_data, prog_ack, cpu_halt, load_done};
    assign ctl = {imem_we, prog_ack, cpu_halt, load_done};

    // Instruction memory as the CPU would see it.
    always @(posedge Clock) if (imem_we === 1'b1) mem_cap[imem_addr] <= imem_data;

    task automatic tick;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Expect the full 32-word BIOS copy starting on the next edge.
    task automatic do_copy(input bit release_expected);
        logic [24:0] exp_v;
        for (int k = 0; k < 32; k++) begin
            tick();
            exp_v = {1'b1, 5'(k), bios_rom[k], 3'b010};
            checks++;
            if (obs !== exp_v) $display("FAIL copy_word[%0d]: got %h want %h", k, obs, exp_v);
            else passes++;
        end
        for (int k = 0; k < 32; k++) exp_mem[k] = bios_rom[k];
        if (release_expected) begin
            tick();
            checks++;
            if (ctl !== 4'b0001) $display("FAIL copy_release: we/ack/halt/done got %b want 0001", ctl);
            else passes++;
        end
        $display("copy complete, release_checked=%0d", release_expected);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 25'b0_00000_0000000000000000_010 || bios_addr !== 5'd0)
                $display("FAIL reset_state[%0d]: got %h/%0d want %h/0", i, obs, bios_addr,
                         25'b0_00000_0000000000000000_010);
            else passes++;
        end
        Reset_n = 1'b1;
        do_copy(1'b1);
    endtask

    task automatic test_single_write;
        prog_addr = 5'd5; prog_data = 16'hA3C4; prog_req = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b1, 5'd5, 16'hA3C4, 3'b111})
            $display("FAIL single_write: got %h want %h", obs, {1'b1, 5'd5, 16'hA3C4, 3'b111});
        else passes++;
        exp_mem[5] = 16'hA3C4;
        prog_req = 1'b0;
        tick();
        checks++;
        if (obs !== {1'b0, 5'd5, 16'hA3C4, 3'b001})
            $display("FAIL single_release: got %h want %h", obs, {1'b0, 5'd5, 16'hA3C4, 3'b001});
        else passes++;
        $display("single write addr=5 data=a3c4");
    endtask

    task automatic test_held_req;
        logic [4:0]  a;
        logic [15:0] d;
        logic [24:0] exp_v;
        int          writes;
        a = 5'($urandom_range(0, 31)); d = 16'($urandom);
        prog_addr = a; prog_data = d; prog_req = 1'b1; writes = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_v = {1'(i % 2), a, d, 1'(i % 2), 2'b11};
            if (imem_we === 1'b1) writes++;
            checks++;
            if (obs !== exp_v) $display("FAIL held_req[%0d]: got %h want %h", i, obs, exp_v);
            else passes++;
        end
        exp_mem[a] = d;
        checks++;
        if (writes != 3) $display("FAIL held_write_count: got %0d want 3", writes);
        else passes++;
        prog_req = 1'b0;
        tick();
        checks++;
        if (ctl !== 4'b0001) $display("FAIL held_release: got %b want 0001", ctl);
        else passes++;
        $display("held request addr=%0d data=%h writes=%0d", a, d, writes);
    endtask

    task automatic test_reload_collision;
        prog_addr = 5'($urandom_range(0, 31)); prog_data = 16'($urandom);
        prog_req = 1'b1; bios_reload = 1'b1;
        tick();
        checks++;
        if (ctl !== 4'b0010) $display("FAIL reload_collision: we/ack/halt/done got %b want 0010", ctl);
        else passes++;
        prog_req = 1'b0; bios_reload = 1'b0;
        do_copy(1'b1);
        $display("reload collision serviced as reload");
    endtask

    task automatic test_reset_midcopy;
        bios_reload = 1'b1;
        tick();
        bios_reload = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (imem_addr !== 5'd16) $display("FAIL midcopy_position: got %0d want 16", imem_addr);
        else passes++;
        Reset_n = 1'b0;
        tick();
        checks++;
        if (obs !== 25'b0_00000_0000000000000000_010 || bios_addr !== 5'd0)
            $display("FAIL midcopy_reset: got %h/%0d want %h/0", obs, bios_addr,
                     25'b0_00000_0000000000000000_010);
        else passes++;
        Reset_n = 1'b1;
        do_copy(1'b1);
        $display("reset at word 17 restarted copy");
    endtask

    task automatic test_prog_during_load;
        logic [4:0]  a;
        logic [15:0] d;
        a = 5'($urandom_range(0, 31)); d = 16'($urandom);
        bios_reload = 1'b1;
        tick();
        bios_reload = 1'b0;
        prog_addr = a; prog_data = d; prog_req = 1'b1;
        do_copy(1'b0);
        tick();
        checks++;
        if (obs !== {1'b1, a, d, 3'b111})
            $display("FAIL load_req_service: got %h want %h", obs, {1'b1, a, d, 3'b111});
        else passes++;
        exp_mem[a] = d;
        prog_req = 1'b0;
        tick();
        checks++;
        if (ctl !== 4'b0001) $display("FAIL load_req_release: got %b want 0001", ctl);
        else passes++;
        $display("request during load serviced addr=%0d data=%h", a, d);
    endtask

    task automatic test_random_writes;
        logic [4:0]  a;
        logic [15:0] d;
        bit          got;
        for (int t = 0; t < 30; t++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            a = 5'($urandom_range(0, 31)); d = 16'($urandom);
            prog_addr = a; prog_data = d; prog_req = 1'b1; got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                tick();
                if (prog_ack === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got) $display("FAIL rand_ack[%0d]: no ack within 4 cycles", t);
            else if (obs !== {1'b1, a, d, 3'b111})
                $display("FAIL rand_write[%0d]: got %h want %h", t, obs, {1'b1, a, d, 3'b111});
            else passes++;
            exp_mem[a] = d;
            prog_req = 1'b0;
            tick();
            checks++;
            if (ctl !== 4'b0001) $display("FAIL rand_release[%0d]: got %b want 0001", t, ctl);
            else passes++;
            $display("txn %0d: write addr=%0d data=%h", t, a, d);
        end
    endtask

    task automatic test_memory_image;
        tick();
        tick();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (mem_cap[k] !== exp_mem[k])
                $display("FAIL mem_image[%0d]: got %h want %h", k, mem_cap[k], exp_mem[k]);
            else passes++;
        end
    endtask

    initial begin
        bios_rom[0] = 16'h0000;
        bios_rom[1] = 16'hE01E;
        for (int k = 2; k < 32; k++) bios_rom[k] = 16'($urandom);
        test_reset();
        test_single_write();
        test_held_req();
        test_reload_collision();
        test_reset_midcopy();
        test_prog_during_load();
        test_random_writes();
        test_memory_image();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
